// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: control/feedback bus between the sweep sequencer and the up/down counter
interface sweep_ctrl_if #(parameter int WIDTH = 8);
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_value;
  logic             cnt_en;
  logic             cnt_up_down;
  logic [WIDTH-1:0] count;
  modport master(output cnt_load, cnt_load_value, cnt_en, cnt_up_down, input count);
  modport slave(input cnt_load, cnt_load_value, cnt_en, cnt_up_down, output count);
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives a loadable up/down counter through repeated lo->hi->lo triangle sweeps
module sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int SW_W  = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [SW_W-1:0]  n_sweeps,
  sweep_ctrl_if.master     cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweep_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [SW_W-1:0]  n_q, n_d, sweep_q, sweep_d, sweep_inc;
  logic             err_q, err_d;
  assign sweep_inc = sweep_q + SW_W'(1);
  // Reversal compares use >=/<= so a disturbed count outside the limits still turns around
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    sweep_d = sweep_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (hi_lim > lo_lim) begin
          state_d = LOAD;
          lo_d    = lo_lim;
          hi_d    = hi_lim;
          n_d     = n_sweeps;
          sweep_d = '0;
        end else err_d = 1'b1;
      end
      LOAD: state_d = stop ? IDLE : UP;
      UP:   state_d = stop ? IDLE : (cnt.count >= hi_q - WIDTH'(1)) ? DOWN : UP;
      DOWN: if (stop) state_d = IDLE;
            else if (cnt.count <= lo_q + WIDTH'(1)) begin
              sweep_d = sweep_inc;
              state_d = (n_q != '0 && sweep_inc == n_q) ? DONE : UP;
            end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end
  assign cnt.cnt_load       = state_q == LOAD;
  assign cnt.cnt_load_value = (state_q == LOAD) ? lo_q : '0;
  assign cnt.cnt_en         = state_q == UP || state_q == DOWN;
  assign cnt.cnt_up_down    = state_q == UP;
  assign busy               = state_q == LOAD || state_q == UP || state_q == DOWN;
  assign done               = state_q == DONE;
  assign err                = err_q;
  assign sweep_cnt          = sweep_q;
endmodule
